draw_queue: RTL and testbench
=============================

DRAW_QUEUE -- requirements
Module: draw_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 Parameter TRI_W, default 324, packed triangle payload width (3 vertices).
REQ-003 Parameter XF_W, default 288, packed transform payload width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 draw_valid  in  1  one-cycle strobe from frame driver: triangle entry present.
REQ-007 camera_transform_valid  in  1  one-cycle strobe: camera transform entry present.
REQ-008 draw_done  in  1  one-cycle strobe, coincident with the last triangle of a frame.
REQ-009 tri_in  in  TRI_W  triangle payload, sampled on a write.
REQ-010 transform_in  in  XF_W  transform payload, sampled on a write.
REQ-011 draw_ready  out  1  frame driver may issue the next entry.
REQ-012 world_busy  out  1  a camera entry is queued or held on the output.
REQ-013 out_valid  out  1  head entry valid toward transform stage.
REQ-014 out_ready  in  1  transform stage accepts the head entry.
REQ-015 out_tri  out  TRI_W  head triangle payload.
REQ-016 out_xform  out  XF_W  head transform payload.
REQ-017 out_is_cam  out  1  head entry is a camera transform; out_tri is don't-care.
REQ-018 out_eof  out  1  head entry is the last triangle of a frame.
REQ-019 overflow  out  1  sticky error: a write arrived while full, or both strobes arrived together.
REQ-020 level  out  $clog2(DEPTH)+1  current entry count.

Function
REQ-021 Write = draw_valid OR camera_transform_valid; each write stores {tri_in, transform_in, is_cam, eof} at wr_ptr in one cycle.
REQ-022 is_cam = camera_transform_valid; eof = draw_done AND draw_valid.
REQ-023 Simultaneous draw_valid and camera_transform_valid: write one entry with is_cam=1, drop the triangle, set overflow.
REQ-024 Write when level==DEPTH and no same-cycle pop: entry dropped, pointers and level unchanged, overflow set.
REQ-025 Write when level==DEPTH with same-cycle pop: accepted, level unchanged.
REQ-026 Pop = out_valid AND out_ready; advances rd_ptr; head payload held stable while out_valid AND NOT out_ready.
REQ-027 Outputs are first-word-fall-through: an entry written into an empty queue at edge N shows out_valid=1 with its payload after edge N, i.e. in the following cycle.
REQ-028 out_valid = (level != 0).
REQ-029 Pointers wrap modulo DEPTH; level increments on write-only, decrements on pop-only, and is unchanged on simultaneous write and pop.
REQ-030 draw_ready = (DEPTH - level) >= 2, combinational; 2-slot margin covers the frame driver's one-cycle registered strobe after sampling ready.
REQ-031 A counter tracks queued camera entries: +1 on camera write, -1 on camera pop; world_busy = counter != 0.
REQ-032 The overflow flag clears only on rst.
REQ-033 No combinational path from out_ready to draw_ready or to world_busy.

Reset
REQ-034 On rst: pointers, level and camera counter = 0.
REQ-035 Reset values: out_valid=0, out_is_cam=0, out_eof=0, overflow=0, world_busy=0, draw_ready=1, level=0.
REQ-036 On rst: storage contents are not cleared; out_tri and out_xform are don't-care while out_valid=0.
REQ-037 rst asserted mid-frame discards all queued entries; the first write after rst release is accepted normally.

Verification
REQ-038 Empty queue, camera strobe with transform_in=X1, out_ready=1 -> next cycle out_valid=1, out_is_cam=1, out_xform=X1, world_busy=1; after the pop, world_busy=0, level=0.
REQ-039 DEPTH=8, out_ready=0, 7 triangle strobes T1..T7 -> draw_ready=0 once level=7; 8th strobe is accepted, 9th is dropped with overflow=1; drain returns T1..T8 in order.
REQ-040 Streaming with write and pop every cycle for 20 cycles -> level constant, no overflow, order preserved across pointer wrap.
REQ-041 Last triangle strobe with draw_done=1 -> that entry pops with out_eof=1; all other entries pop with out_eof=0.
REQ-042 Both strobes in the same cycle -> single entry with out_is_cam=1, overflow=1, level +1.
REQ-043 rst pulsed with level=5 -> level=0, out_valid=0, draw_ready=1, overflow=0 immediately; a following write appears at the head the next cycle.

Source files
------------

// File: rtl/draw_queue.sv
// Draw queue: FWFT buffer of triangle and camera-transform entries
// between the frame driver and the transform stage.
module draw_queue #(
  parameter int DEPTH = 8,
  parameter int TRI_W = 324,
  parameter int XF_W  = 288
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       draw_valid,
  input  logic                       camera_transform_valid,
  input  logic                       draw_done,
  input  logic [TRI_W-1:0]           tri_in,
  input  logic [XF_W-1:0]            transform_in,
  output logic                       draw_ready,
  output logic                       world_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TRI_W-1:0]           out_tri,
  output logic [XF_W-1:0]            out_xform,
  output logic                       out_is_cam,
  output logic                       out_eof,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TRI_W-1:0] tri_mem [DEPTH];
  logic [XF_W-1:0]  xf_mem  [DEPTH];
  logic             cam_mem [DEPTH];
  logic             eof_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] cam_cnt;
  logic          ovf_q;

  logic wr;
  logic full;
  logic pop;
  logic accept;
  logic cam_in;
  logic cam_out;
  logic both;

  assign wr      = draw_valid | camera_transform_valid;
  assign both    = draw_valid & camera_transform_valid;
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = out_valid & out_ready;
  assign accept  = wr & (~full | pop);
  assign cam_in  = accept & camera_transform_valid;
  assign cam_out = pop & cam_mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tri_mem[wr_ptr] <= tri_in;
      xf_mem[wr_ptr]  <= transform_in;
      cam_mem[wr_ptr] <= camera_transform_valid;
      eof_mem[wr_ptr] <= draw_done & draw_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      cam_cnt <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      unique case ({cam_in, cam_out})
        2'b10:   cam_cnt <= cam_cnt + LW'(1);
        2'b01:   cam_cnt <= cam_cnt - LW'(1);
        default: cam_cnt <= cam_cnt;
      endcase
      if (both | (wr & full & ~pop))
        ovf_q <= 1'b1;
    end
  end

  // Status outputs come from registered state only.
  assign out_valid  = (level_q != '0);
  assign out_tri    = tri_mem[rd_ptr];
  assign out_xform  = xf_mem[rd_ptr];
  assign out_is_cam = out_valid & cam_mem[rd_ptr];
  assign out_eof    = out_valid & eof_mem[rd_ptr];
  assign draw_ready = (LW'(DEPTH) - level_q) >= LW'(2);
  assign world_busy = (cam_cnt != '0);
  assign overflow   = ovf_q;
  assign level      = level_q;

endmodule

// File: tb/tb_draw_queue.sv
// Bench for draw_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_draw_queue;

  localparam int DEPTH = 8;
  localparam int TRI_W = 324;
  localparam int XF_W  = 288;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             draw_valid = 1'b0;
  logic             camera_transform_valid = 1'b0;
  logic             draw_done = 1'b0;
  logic [TRI_W-1:0] tri_in = '0;
  logic [XF_W-1:0]  transform_in = '0;
  logic             draw_ready;
  logic             world_busy;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TRI_W-1:0] out_tri;
  logic [XF_W-1:0]  out_xform;
  logic             out_is_cam;
  logic             out_eof;
  logic             overflow;
  logic [LW-1:0]    level;

  draw_queue #(.DEPTH(DEPTH), .TRI_W(TRI_W), .XF_W(XF_W)) dut (
    .clk(clk),
    .rst(rst),
    .draw_valid(draw_valid),
    .camera_transform_valid(camera_transform_valid),
    .draw_done(draw_done),
    .tri_in(tri_in),
    .transform_in(transform_in),
    .draw_ready(draw_ready),
    .world_busy(world_busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tri(out_tri),
    .out_xform(out_xform),
    .out_is_cam(out_is_cam),
    .out_eof(out_eof),
    .overflow(overflow),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TRI_W-1:0] t;
    logic [XF_W-1:0]  x;
    bit               cam;
    bit               eof;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cam_count();
    int n = 0;
    foreach (q[i]) if (q[i].cam) n++;
    return n;
  endfunction

  task automatic check_all();
    int n = q.size();
    chk("level", 512'(level), 512'(n));
    chk("out_valid", 512'(out_valid), 512'(n != 0));
    chk("draw_ready", 512'(draw_ready), 512'((DEPTH - n) >= 2));
    chk("world_busy", 512'(world_busy), 512'(cam_count() != 0));
    chk("overflow", 512'(overflow), 512'(m_ovf));
    if (n != 0) begin
      chk("out_is_cam", 512'(out_is_cam), 512'(q[0].cam));
      chk("out_eof", 512'(out_eof), 512'(q[0].eof));
      chk("out_xform", 512'(out_xform), 512'(q[0].x));
      if (!q[0].cam)
        chk("out_tri", 512'(out_tri), 512'(q[0].t));
    end else begin
      chk("out_is_cam_empty", 512'(out_is_cam), 512'(0));
      chk("out_eof_empty", 512'(out_eof), 512'(0));
    end
  endtask

  function automatic logic [TRI_W-1:0] rnd_tri();
    logic [TRI_W-1:0] r;
    for (int i = 0; i < TRI_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [XF_W-1:0] rnd_xf();
    logic [XF_W-1:0] r;
    for (int i = 0; i < XF_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One cycle: check outputs at negedge, drive inputs, update model at posedge.
  task automatic step(input bit dv, input bit cv, input bit dd,
                      input bit ordy);
    ent_t e;
    bit   full;
    bit   pop;
    @(negedge clk);
    check_all();
    draw_valid = dv;
    camera_transform_valid = cv;
    draw_done = dd;
    out_ready = ordy;
    tri_in = rnd_tri();
    transform_in = rnd_xf();
    @(posedge clk);
    full = (q.size() == DEPTH);
    pop = (q.size() != 0) && ordy;
    if (dv && cv) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (dv || cv) begin
      if (!full || pop) begin
        e.t = tri_in;
        e.x = transform_in;
        e.cam = cv;
        e.eof = dd && dv;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    draw_valid = 1'b0;
    camera_transform_valid = 1'b0;
    draw_done = 1'b0;
    out_ready = 1'b0;
    q.delete();
    m_ovf = 0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_ovf = 0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Camera entry through an empty queue.
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Fill to full with output stalled, overrun by one, then drain.
    for (int i = 0; i < 9; i++) step(1, 0, (i == 8), 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);

    pulse_reset();

    // Streaming across pointer wrap with a frame boundary.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, (i == 19), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Both strobes together.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // Mid-frame reset at level 5, then a fresh write.
    pulse_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, ($urandom % 8) == 0,
           ($urandom % 4) == 0, ($urandom % 5) < 3);
      if (i == 200) pulse_reset();
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
